sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single-port SDRAM controller (valid/ready, 32-bit, byte-strobed) among NUM_PORTS requesters
//  (e.g. instruction fetch, data bus, DMA). Round-robin, one transaction at a time. Request fields are
//  registered and held stable for the whole SDRAM transaction, since the controller samples addr more than once.
//  Sits between the bus fabric and the SDRAM controller.
// PARAMETERS
//  NUM_PORTS  3   number of requester ports (2..8)
//  PTR_W      2   width of grant index, = clog2(NUM_PORTS)
// PORTS
//  clk        in   1            single clock, shared with SDRAM controller
//  rst        in   1            synchronous reset, active-high
//  s_valid    in   NUM_PORTS    per-port request; held until matching s_ready
//  s_ready    out  NUM_PORTS    one-cycle completion pulse per port
//  s_addr     in   NUM_PORTS*32 per-port address, port i at [32*i+:32]
//  s_wdata    in   NUM_PORTS*32 per-port write data
//  s_wstrb    in   NUM_PORTS*4  per-port byte strobes; 0 = read
//  s_rdata    out  32           read data, broadcast; valid only with s_ready
//  m_valid    out  1            request to SDRAM controller
//  m_ready    in   1            controller completion pulse
//  m_addr     out  32           registered address to controller
//  m_wdata    out  32           registered write data
//  m_wstrb    out  4            registered strobes
//  m_rdata    in   32           controller read data, valid with m_ready
//  init_done  in   1            controller initialisation complete; no grants before it is 1
//  grant      out  NUM_PORTS    one-hot owner of current transaction, 0 when idle
// BEHAVIOUR
//  Reset values: s_ready=0, s_rdata=0, m_valid=0, m_addr/m_wdata/m_wstrb=0, grant=0, last_ptr=NUM_PORTS-1,
//  state=IDLE.
//  FSM IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE: if init_done && |s_valid, pick winner w. Search starts at last_ptr+1 mod NUM_PORTS.
//     Register s_addr/s_wdata/s_wstrb[w] into m_*, set grant=1<<w, last_ptr=w, m_valid=1, go to ISSUE.
//     Otherwise stay in IDLE.
//   ISSUE: m_valid held at 1 and m_* held stable until m_ready=1. On m_ready: m_valid<=0, s_rdata<=m_rdata,
//     s_ready[w]<=1, go to RESP.
//   RESP: s_ready[w] is high for exactly this cycle, then cleared. grant<=0, go to IDLE.
//  Latency: request seen in IDLE at cycle 0 gives m_valid at cycle 1. m_ready at cycle k gives s_ready at cycle k+1.
//  Minimum 3 cycles between successive grants. The controller's tRP tail absorbs the gap.
//  s_ready never asserts on a port that has no grant. At most one s_ready bit is high at a time.
//  Simultaneous requests: rotation order decides. A port that keeps s_valid high waits at most NUM_PORTS-1 grants.
//  A requester dropping s_valid while granted does not abort: the transaction completes and s_ready still pulses.
//  m_ready while in IDLE or RESP is ignored. An unexpected m_ready in RESP produces no second s_ready.
//  init_done=0: stay in IDLE, ignore all requests. If init_done falls in ISSUE, finish the current transaction.
//  Reset mid-transaction: immediate return to IDLE with all outputs at reset values. The controller is reset by the
//  same system reset.
// CONFIGURATION
//  SDRAM_ARB_PRIO0_EN defined: port 0 wins whenever s_valid[0]=1 in IDLE. Other ports rotate among themselves.
//    last_ptr is updated only by grants to ports 1..NUM_PORTS-1.
//  Undefined: pure round-robin over all ports, as described above.
// STRUCTURE
//  Header sdram_arb_defs.vh: state encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2, and default NUM_PORTS.
//  Sub-module rr_pick: combinational round-robin picker. Inputs: req[NUM_PORTS], last_ptr.
//    Outputs: any, idx[PTR_W], onehot. The arbiter holds all state.
// TESTING
//  1 init_done=0, s_valid=3'b111 for 50 cycles -> m_valid stays 0, s_ready stays 0.
//  2 Port1 reads addr 0x100, controller model returns 0xDEADBEEF at m_ready -> s_ready=3'b010 one cycle later with
//    s_rdata=0xDEADBEEF. m_addr=0x100 held constant from m_valid rise to m_ready.
//  3 All three ports hold requests from reset (last_ptr=2) -> grant order 0,1,2,0,1,2. No s_ready on a non-owner.
//  4 Port2 writes 0x12345678 with wstrb=4'b0011. s_addr[2] changes to 0xFFFF mid-transaction -> m_addr, m_wdata and
//    m_wstrb remain 0x..., 0x12345678, 4'b0011 until m_ready.
//  5 rst=1 while in ISSUE -> next cycle m_valid=0, grant=0, s_ready=0. After release, the first grant goes to port 0.
//  6 With SDRAM_ARB_PRIO0_EN, port0 and port1 request continuously -> port0 wins every grant.
//    Drop port0 -> port1 is granted in the next IDLE.

Source files
------------

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: shared constants for the SDRAM port arbiter.
// FSM state encodings and the default port count.
package sdram_arbiter_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam int         DEF_NUM_PORTS = 3;
endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Returns the first requesting port after last_ptr, wrapping mod NUM_PORTS.
module rr_pick #(
    parameter int NUM_PORTS = 3,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     last_ptr,
    output logic                 any,
    output logic [PTR_W-1:0]     idx,
    output logic [NUM_PORTS-1:0] onehot
);
    int c;

    // Walk candidates farthest-first so the nearest requester after last_ptr wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        c      = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            c = (int'(last_ptr) + k) % NUM_PORTS;
            if (req[c]) begin
                any       = 1'b1;
                idx       = PTR_W'(c);
                onehot    = '0;
                onehot[c] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller among NUM_PORTS requesters,
// one transaction at a time, with request fields registered for the whole
// transaction. Optional macro SDRAM_ARB_PRIO0_EN gives port 0 absolute
// priority; the remaining ports rotate among themselves.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int PTR_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    s_valid,
    output logic [NUM_PORTS-1:0]    s_ready,
    input  logic [NUM_PORTS*32-1:0] s_addr,
    input  logic [NUM_PORTS*32-1:0] s_wdata,
    input  logic [NUM_PORTS*4-1:0]  s_wstrb,
    output logic [31:0]             s_rdata,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_addr,
    output logic [31:0]             m_wdata,
    output logic [3:0]              m_wstrb,
    input  logic [31:0]             m_rdata,
    input  logic                    init_done,
    output logic [NUM_PORTS-1:0]    grant
);
    logic [1:0]           state_q, state_d;
    logic [PTR_W-1:0]     last_ptr_q, last_ptr_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] s_ready_q, s_ready_d;
    logic [31:0]          s_rdata_q, s_rdata_d;
    logic                 m_valid_q, m_valid_d;
    logic [31:0]          m_addr_q, m_addr_d;
    logic [31:0]          m_wdata_q, m_wdata_d;
    logic [3:0]           m_wstrb_q, m_wstrb_d;

    logic [NUM_PORTS-1:0] pick_req, pick_oh, win_oh;
    logic                 pick_any, win_any, win_upd;
    logic [PTR_W-1:0]     pick_idx, win_idx;

    rr_pick #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_pick (
        .req      (pick_req),
        .last_ptr (last_ptr_q),
        .any      (pick_any),
        .idx      (pick_idx),
        .onehot   (pick_oh)
    );

    // Winner selection: optional port-0 override in front of the rotation.
    always_comb begin
`ifdef SDRAM_ARB_PRIO0_EN
        pick_req    = s_valid;
        pick_req[0] = 1'b0;
        if (s_valid[0]) begin
            win_any = 1'b1;
            win_idx = '0;
            win_oh  = NUM_PORTS'(1);
            win_upd = 1'b0;       // port 0 does not disturb the rotation
        end else begin
            win_any = pick_any;
            win_idx = pick_idx;
            win_oh  = pick_oh;
            win_upd = 1'b1;
        end
`else
        pick_req = s_valid;
        win_any  = pick_any;
        win_idx  = pick_idx;
        win_oh   = pick_oh;
        win_upd  = 1'b1;
`endif
    end

    // Next-state: IDLE grants and latches fields, ISSUE waits for completion, RESP drops grant.
    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        grant_d    = grant_q;
        s_ready_d  = '0;
        s_rdata_d  = s_rdata_q;
        m_valid_d  = m_valid_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (init_done && win_any) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (win_idx == PTR_W'(i)) begin
                            m_addr_d  = s_addr[32*i +: 32];
                            m_wdata_d = s_wdata[32*i +: 32];
                            m_wstrb_d = s_wstrb[4*i +: 4];
                        end
                    end
                    grant_d   = win_oh;
                    m_valid_d = 1'b1;
                    state_d   = ST_ISSUE;
                    if (win_upd) last_ptr_d = win_idx;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    s_rdata_d = m_rdata;
                    s_ready_d = grant_q;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d   = '0;
                m_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_ptr_q <= PTR_W'(NUM_PORTS-1);
            grant_q    <= '0;
            s_ready_q  <= '0;
            s_rdata_q  <= '0;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            grant_q    <= grant_d;
            s_ready_q  <= s_ready_d;
            s_rdata_q  <= s_rdata_d;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
        end
    end

    assign s_ready = s_ready_q;
    assign s_rdata = s_rdata_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign grant   = grant_q;
endmodule
